// File: rtl/avalon_pio_ctrl.sv
// Avalon-MM PIO slave: output register with atomic set/clear, synchronised inputs with edge capture and IRQ.
// Optional self-timed pulse register at address 6 is built only when PIO_PULSE_EN is defined.
module avalon_pio_ctrl #(
   parameter int unsigned      WIDTH        = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter int unsigned      EDGE_TYPE    = 0,
   parameter int unsigned      PULSE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_INPUT  = 3'd1;
   localparam logic [2:0] A_MASK   = 3'd2;
   localparam logic [2:0] A_EDGE   = 3'd3;
   localparam logic [2:0] A_OUTSET = 3'd4;
   localparam logic [2:0] A_OUTCLR = 3'd5;
   localparam logic [2:0] A_PULSE  = 3'd6;

   logic             wr;
   logic [WIDTH-1:0] wd;
   logic             unused_wd;

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
   logic [1:0]       fill_q;
   logic             primed_q;
   logic             irq_q;
   logic [WIDTH-1:0] det;
   logic [WIDTH-1:0] set_bits, clr_bits, pulse_set, exp_clr;

   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;
   assign set_bits  = (wr && address == A_OUTSET) ? wd : '0;
   assign clr_bits  = (wr && address == A_OUTCLR) ? wd : '0;

   always_comb begin
      case (EDGE_TYPE)
         0:       det = sync2_q & ~prev_q;
         1:       det = ~sync2_q & prev_q;
         default: det = sync2_q ^ prev_q;
      endcase
   end

`ifdef PIO_PULSE_EN
   logic [WIDTH-1:0] pmask_q, pmask_d;
   logic [15:0]      pcnt_q, pcnt_d;
   logic             pulse_wr;

   assign pulse_wr = wr && address == A_PULSE && (|wd);

   // A reload on the expiry cycle wins over the expiry clear.
   always_comb begin
      pcnt_d    = pcnt_q;
      pmask_d   = pmask_q;
      pulse_set = '0;
      exp_clr   = '0;
      if (wr && address == A_DATA) begin
         pcnt_d  = '0;
         pmask_d = '0;
      end else if (pulse_wr) begin
         pcnt_d    = 16'(PULSE_CYCLES);
         pmask_d   = pmask_q | wd;
         pulse_set = wd;
      end else if (pcnt_q != '0) begin
         pcnt_d = pcnt_q - 16'd1;
         if (pcnt_q == 16'd1) begin
            pmask_d = '0;
            exp_clr = pmask_q & ~set_bits;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pcnt_q  <= '0;
         pmask_q <= '0;
      end else begin
         pcnt_q  <= pcnt_d;
         pmask_q <= pmask_d;
      end
   end
`else
   assign pulse_set = '0;
   assign exp_clr   = '0;
`endif

   always_comb begin
      if (wr && address == A_DATA) out_d = wd;
      else                         out_d = (out_q | set_bits | pulse_set) & ~(clr_bits | exp_clr);
      irqmask_d = (wr && address == A_MASK) ? wd : irqmask_q;
      // A new edge beats a simultaneous write-1-to-clear.
      edge_d = (edge_q & ~((wr && address == A_EDGE) ? wd : '0)) | (primed_q ? det : '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q     <= RESET_VALUE;
         irqmask_q <= '0;
         edge_q    <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         fill_q    <= '0;
         primed_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         irqmask_q <= irqmask_d;
         edge_q    <= edge_d;
         sync1_q   <= in_port;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         fill_q    <= {fill_q[0], 1'b1};
         primed_q  <= fill_q[1];
         irq_q     <= |(edge_q & irqmask_q);
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         A_DATA:  readdata[WIDTH-1:0] = out_q;
         A_INPUT: readdata[WIDTH-1:0] = sync2_q;
         A_MASK:  readdata[WIDTH-1:0] = irqmask_q;
         A_EDGE:  readdata[WIDTH-1:0] = edge_q;
`ifdef PIO_PULSE_EN
         A_PULSE: readdata[15:0]      = pcnt_q;
`endif
         default: readdata = '0;
      endcase
   end

   assign out_port = out_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_ctrl.sv
// Directed self-checking bench for avalon_pio_ctrl (WIDTH=8, RESET_VALUE=8'hA5, rising edges, 16-cycle pulse).
module tb_avalon_pio_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic [7:0]  out_port;
   logic        irq;

   int checks = 0;
   int passes = 0;

   avalon_pio_ctrl #(
      .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .PULSE_CYCLES(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .out_port(out_port), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic rd_addr(input logic [2:0] a);
      address = a; #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; in_port = 8'hFF; address = 3'd0; chipselect = 1'b0;
      write_n = 1'b1; writedata = '0;
      step(3);
      reset_n = 1'b1;
      rd_addr(3'd0);
      checks++; if (out_port !== 8'hA5) $display("FAIL reset_out: got %h exp %h", out_port, 8'hA5); else passes++;
      checks++; if (readdata !== 32'h000000A5) $display("FAIL reset_rd0: got %h exp %h", readdata, 32'hA5); else passes++;
      checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b exp 0", irq); else passes++;
      step(6);
      rd_addr(3'd3);
      checks++; if (readdata !== 32'h0) $display("FAIL reset_edge: got %h exp 0", readdata); else passes++;
      rd_addr(3'd1);
      checks++; if (readdata !== 32'hFF) $display("FAIL reset_input: got %h exp ff", readdata); else passes++;
      checks++; if (irq !== 1'b0) $display("FAIL reset_irq_late: got %b exp 0", irq); else passes++;
   endtask

   task automatic test_output;
      wr_reg(3'd0, 32'hFFFF_FF0F);
      checks++; if (out_port !== 8'h0F) $display("FAIL data_wr: got %h exp 0f", out_port); else passes++;
      rd_addr(3'd0);
      checks++; if (readdata !== 32'h0F) $display("FAIL data_rd: got %h exp 0f", readdata); else passes++;
      wr_reg(3'd4, 32'h30);
      checks++; if (out_port !== 8'h3F) $display("FAIL outset: got %h exp 3f", out_port); else passes++;
      checks++; if (readdata !== 32'h0) $display("FAIL outset_rd: got %h exp 0", readdata); else passes++;
      wr_reg(3'd5, 32'h03);
      checks++; if (out_port !== 8'h3C) $display("FAIL outclr: got %h exp 3c", out_port); else passes++;
      wr_reg(3'd7, 32'hFF);
      checks++; if (out_port !== 8'h3C || readdata !== 32'h0) $display("FAIL addr7: out %h rd %h exp 3c/0", out_port, readdata); else passes++;
   endtask

   task automatic test_edge;
      in_port = 8'hFB;
      step(5);
      rd_addr(3'd3);
      checks++; if (readdata !== 32'h0) $display("FAIL falling_ignored: got %h exp 0", readdata); else passes++;
      wr_reg(3'd2, 32'h04);
      rd_addr(3'd2);
      checks++; if (readdata !== 32'h04) $display("FAIL irqmask_rd: got %h exp 04", readdata); else passes++;
      in_port = 8'hFF;
      rd_addr(3'd3);
      step(2);
      checks++; if (readdata !== 32'h0) $display("FAIL edge_early: got %h exp 0", readdata); else passes++;
      step(1);
      checks++; if (readdata !== 32'h04 || irq !== 1'b0) $display("FAIL edge_3cyc: edge %h irq %b exp 04/0", readdata, irq); else passes++;
      step(1);
      checks++; if (irq !== 1'b1) $display("FAIL irq_assert: got %b exp 1", irq); else passes++;
      wr_reg(3'd3, 32'h04);
      step(1);
      checks++; if (irq !== 1'b0 || readdata !== 32'h0) $display("FAIL w1c: irq %b edge %h exp 0/0", irq, readdata); else passes++;
      // clear lands on the same edge the new rising edge is captured
      in_port = 8'hFB;
      step(4);
      in_port = 8'hFF;
      step(2);
      wr_reg(3'd3, 32'h04);
      rd_addr(3'd3);
      checks++; if (readdata !== 32'h04) $display("FAIL w1c_vs_edge: got %h exp 04", readdata); else passes++;
      step(1);
      checks++; if (irq !== 1'b1) $display("FAIL w1c_vs_edge_irq: got %b exp 1", irq); else passes++;
      wr_reg(3'd3, 32'h04);
      in_port = 8'hFE;
      step(4);
      in_port = 8'hFF;
      step(4);
      rd_addr(3'd3);
      checks++; if (readdata !== 32'h01 || irq !== 1'b0) $display("FAIL unmasked_edge: edge %h irq %b exp 01/0", readdata, irq); else passes++;
   endtask

`ifdef PIO_PULSE_EN
   task automatic test_pulse;
      wr_reg(3'd0, 32'h0);
      wr_reg(3'd6, 32'h01);
      checks++; if (out_port !== 8'h01 || readdata !== 32'd16) $display("FAIL pulse_start: out %h cnt %0d exp 01/16", out_port, readdata); else passes++;
      for (int k = 1; k <= 16; k++) begin
         step(1);
         checks++; if (readdata !== 32'(16 - k)) $display("FAIL pulse_cnt%0d: got %0d exp %0d", k, readdata, 16 - k); else passes++;
         checks++; if (out_port !== ((k < 16) ? 8'h01 : 8'h00)) $display("FAIL pulse_out%0d: got %h", k, out_port); else passes++;
      end
      wr_reg(3'd6, 32'h0);
      checks++; if (readdata !== 32'h0 || out_port !== 8'h00) $display("FAIL pulse_zero: cnt %0d out %h exp 0/00", readdata, out_port); else passes++;
   endtask

   task automatic test_pulse_extend;
      wr_reg(3'd6, 32'h01);
      step(11);
      checks++; if (readdata !== 32'd5) $display("FAIL ext_cnt5: got %0d exp 5", readdata); else passes++;
      wr_reg(3'd6, 32'h02);
      checks++; if (out_port !== 8'h03 || readdata !== 32'd16) $display("FAIL ext_reload: out %h cnt %0d exp 03/16", out_port, readdata); else passes++;
      step(15);
      checks++; if (out_port !== 8'h03 || readdata !== 32'd1) $display("FAIL ext_hold: out %h cnt %0d exp 03/1", out_port, readdata); else passes++;
      step(1);
      checks++; if (out_port !== 8'h00 || readdata !== 32'd0) $display("FAIL ext_end: out %h cnt %0d exp 00/0", out_port, readdata); else passes++;
      wr_reg(3'd6, 32'h01);
      step(3);
      wr_reg(3'd0, 32'h80);
      rd_addr(3'd6);
      checks++; if (out_port !== 8'h80 || readdata !== 32'd0) $display("FAIL data_cancel: out %h cnt %0d exp 80/0", out_port, readdata); else passes++;
      step(20);
      checks++; if (out_port !== 8'h80) $display("FAIL data_cancel_hold: got %h exp 80", out_port); else passes++;
      wr_reg(3'd6, 32'h03);
      step(15);
      wr_reg(3'd4, 32'h01);
      checks++; if (out_port !== 8'h81) $display("FAIL outset_expiry: got %h exp 81", out_port); else passes++;
   endtask
`else
   task automatic test_pulse_disabled;
      wr_reg(3'd0, 32'h00);
      wr_reg(3'd6, 32'hFF);
      checks++; if (out_port !== 8'h00) $display("FAIL nopulse_out: got %h exp 00", out_port); else passes++;
      rd_addr(3'd6);
      checks++; if (readdata !== 32'h0) $display("FAIL nopulse_rd: got %h exp 0", readdata); else passes++;
      step(20);
      checks++; if (out_port !== 8'h00) $display("FAIL nopulse_hold: got %h exp 00", out_port); else passes++;
   endtask
`endif

   initial begin
      test_reset;
      test_output;
      test_edge;
`ifdef PIO_PULSE_EN
      test_pulse;
      test_pulse_extend;
`else
      test_pulse_disabled;
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/avalon_pio_ctrl.md
Name: avalon_pio_ctrl

Overview:
- Parametrised Avalon-MM slave PIO that replaces the single-bit output-only control ports in the SoC, such as peripheral reset lines.
- Provides a WIDTH-bit output register with atomic set/clear, synchronised inputs with edge capture and a maskable IRQ.
- Provides a self-timed pulse register for reset-style strobes, so software no longer has to busy-wait.
- Sits on the system interconnect; one instance per GPIO/control group.

Parameters:
- WIDTH, 8, number of output and input bits (1..32).
- RESET_VALUE, 0, out_port value after reset.
- EDGE_TYPE, 0, edge capture mode: 0 rising, 1 falling, 2 any.
- PULSE_CYCLES, 16, pulse length in clk cycles (1..65535).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset: asynchronous, active-low (reset reset_n, asynchronous, active-low; clock clk).
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  read data, combinational, zero wait states; zero-extended above WIDTH.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  registered outputs.
- irq  out  1  level interrupt.

Behaviour:
- Write strobe: wr = chipselect & ~write_n. readdata is valid whenever address is stable; chipselect is not required for reads.
- Register map:
  - 0 DATA: RW; a write loads out_port.
  - 1 INPUT: RO; synchronised in_port.
  - 2 IRQMASK: RW.
  - 3 EDGE: read returns captured edges; write-1-to-clear.
  - 4 OUTSET: WO; out |= wd; reads 0.
  - 5 OUTCLR: WO; out &= ~wd; reads 0.
  - 6 PULSE: W starts a pulse; R returns remaining count in [15:0].
  - 7: reads 0, writes ignored.
- Write effect on out_port is visible the cycle after the write.
- Reset values:
  - out_port = RESET_VALUE.
  - irqmask, edge, sync stages, pulse_mask, pulse_cnt = 0.
  - irq = 0; primed = 0.
- Input path:
  - 2-flop synchroniser, then a prev register.
  - Edge detection uses sync vs prev; latency in_port -> EDGE bit set is 3 cycles.
  - primed sets 1 cycle after the synchroniser fills. Until then no edges are captured, so no spurious edge occurs after reset.
- EDGE bits are sticky. A W1C and a new edge on the same bit in the same cycle: the bit ends set.
- irq = |(edge & irqmask), registered; asserts 1 cycle after the EDGE bit sets.
- Pulse write (wd != 0):
  - out |= wd; pulse_mask |= wd; pulse_cnt = PULSE_CYCLES.
  - Each following cycle: if cnt != 0 then cnt--.
  - On the cycle cnt goes 1 -> 0: out &= ~pulse_mask; pulse_mask = 0.
  - Pulsed bits are high for exactly PULSE_CYCLES cycles.
  - A pulse write of 0 is ignored.
- Pulse write while a pulse is active: mask ORs in the new bits and the count reloads, extending the pulse for all pulsed bits.
- DATA write while a pulse is active: the DATA value wins entirely; the pulse is cancelled (cnt = 0, mask = 0).
- OUTSET on the expiry cycle: set bits stay 1 and are removed from the expiry clear; other mask bits clear.
- OUTCLR on the expiry cycle: union of both clears.
- OUTSET/OUTCLR during an active pulse (non-expiry cycle): applied immediately; pulse_mask unchanged.
- Reset mid-pulse: immediate return to reset values; no residual pulse.

Optional Feature:
- Macro: PIO_PULSE_EN.
- Defined: PULSE register, counter and mask are implemented as above.
- Undefined: address 6 behaves like address 7 (reads 0, writes ignored); no counter logic; out_port changes only via DATA/OUTSET/OUTCLR.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata@0=32'h000000A5, irq=0; in_port held 8'hFF through reset -> EDGE reads 0.
- Write DATA=8'h0F, OUTSET=8'h30, OUTCLR=8'h03 -> out_port 8'h0F, 8'h3F, 8'h3C, each one cycle after its write.
- EDGE_TYPE=0, IRQMASK=8'h04, in_port bit2 0->1 -> EDGE=8'h04 after 3 cycles, irq high next cycle; W1C 8'h04 -> irq low; W1C coinciding with a new edge -> bit remains 1.
- PULSE_CYCLES=16, DATA=0, PULSE write 8'h01 -> out_port[0] high exactly 16 cycles; readdata@6 counts 16..0.
- PULSE 8'h01, then at cnt=5 PULSE 8'h02 -> bits 0 and 1 high until 16 cycles after the second write; DATA write 8'h80 mid-pulse -> out_port=8'h80, count 0.
- Build without PIO_PULSE_EN: PULSE write 8'hFF -> out_port unchanged, readdata@6=0.
